// File: rtl/decoder3_8_stream.sv
// rtl/decoder3_8_stream.sv - position stream to one-hot word rebuilder with output FIFO
module decoder3_8_stream #(
    parameter int IN_W       = 3,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_W-1:0]      in_pos,
    input  logic                 in_none,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2**IN_W-1:0]   out_data,
    output logic [IN_W:0]        out_count,
    output logic                 out_dup
);
    localparam int OW  = 2**IN_W;
    localparam int CW  = IN_W + 1;
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t           state, state_nxt;
    logic [OW-1:0]    acc, acc_nxt, beat_bit, acc_sum;
    logic [CW-1:0]    cnt, cnt_nxt, cnt_inc;
    logic             dup, dup_nxt, dup_sum;
    logic             accept, push, pop;

    logic [OW-1:0]    mem_data  [FIFO_DEPTH];
    logic [CW-1:0]    mem_count [FIFO_DEPTH];
    logic             mem_dup   [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [OCW-1:0]   occ;

    // rst gates in_ready so nothing is reported ready while the block is held in reset
    assign in_ready  = !rst && (occ < OCW'(FIFO_DEPTH));
    assign out_valid = (occ != '0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign beat_bit = in_none ? '0 : (OW'(1) << in_pos);
    assign acc_sum  = acc | beat_bit;
    assign dup_sum  = dup | (|(acc & beat_bit));
    assign cnt_inc  = (cnt == '1) ? cnt : cnt + CW'(1);

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        dup_nxt   = dup;
        push      = 1'b0;
        if (accept) begin
            case (state)
                IDLE, ACCUM: begin
                    if (in_last) begin
                        push      = 1'b1;
                        state_nxt = IDLE;
                        acc_nxt   = '0;
                        cnt_nxt   = '0;
                        dup_nxt   = 1'b0;
                    end else begin
                        state_nxt = ACCUM;
                        acc_nxt   = acc_sum;
                        cnt_nxt   = cnt_inc;
                        dup_nxt   = dup_sum;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            dup   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            dup   <= dup_nxt;
        end
    end

    // The pushed word includes the closing beat, hence the *_sum / cnt_inc values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data[i]  <= '0;
                mem_count[i] <= '0;
                mem_dup[i]   <= 1'b0;
            end
        end else begin
            if (push) begin
                mem_data[wr_ptr]  <= acc_sum;
                mem_count[wr_ptr] <= cnt_inc;
                mem_dup[wr_ptr]   <= dup_sum;
                wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                occ <= occ + OCW'(1);
            end else if (pop && !push) begin
                occ <= occ - OCW'(1);
            end
        end
    end

    assign out_data  = out_valid ? mem_data[rd_ptr]  : '0;
    assign out_count = out_valid ? mem_count[rd_ptr] : '0;
    assign out_dup   = out_valid ? mem_dup[rd_ptr]   : 1'b0;

endmodule
